// File: rtl/systolic_pkg.sv
// Shared constants and state type for the systolic chain's result path.
package systolic_pkg;

  localparam int unsigned N_PE            = 4;
  localparam int unsigned ACC_W           = 16;
  localparam logic [7:0]  SYNC_BYTE       = 8'hA5;
  localparam int unsigned BYTES_PER_FRAME = N_PE * ACC_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } drain_state_t;

endpackage

// File: rtl/systolic_result_drain_if.sv
// Valid/ready byte stream carrying framed results toward the host pins.
interface systolic_result_drain_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/systolic_result_drain.sv
// Snapshots the accumulator set on completion and streams it out as
// sync byte, little-endian data bytes and an XOR checksum.
module systolic_result_drain #(
  parameter int unsigned N_PE      = systolic_pkg::N_PE,
  parameter int unsigned ACC_W     = systolic_pkg::ACC_W,
  parameter logic [7:0]  SYNC_BYTE = systolic_pkg::SYNC_BYTE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_PE*ACC_W-1:0]   acc_in,
  input  logic                    acc_valid,
  systolic_result_drain_if.master tx,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  input  logic                    clr_ovr
);
  import systolic_pkg::*;

  localparam int unsigned SnapW = N_PE * ACC_W;
  localparam int unsigned Bytes = SnapW / 8;
  localparam int unsigned IdxW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Bytes - 1);

  drain_state_t     state_q, state_d;
  logic [SnapW-1:0] snap_q, snap_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic             ovr_q, ovr_d;

  logic hs;
  logic accept;
  logic ovr_set;

  assign hs = tx.tx_valid & tx.tx_ready;
  // A new result set is taken when idle, or exactly as the checksum leaves.
  assign accept  = acc_valid & ((state_q == IDLE) | ((state_q == CSUM) & hs));
  assign ovr_set = acc_valid & ~accept;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    unique case (state_q)
      IDLE: ;
      HDR: begin
        if (hs) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (hs) begin
          csum_d = csum_q ^ tx.tx_data;
          idx_d  = idx_q + 1'b1;
          if (idx_q == LastIdx) state_d = CSUM;
        end
      end
      CSUM: begin
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      snap_d  = acc_in;
      csum_d  = '0;
      state_d = HDR;
    end
  end

  always_comb begin
    if (ovr_set)      ovr_d = 1'b1;
    else if (clr_ovr) ovr_d = 1'b0;
    else              ovr_d = ovr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    tx.tx_data = 8'h00;
    unique case (state_q)
      IDLE:    tx.tx_data = 8'h00;
      HDR:     tx.tx_data = SYNC_BYTE;
      DATA:    tx.tx_data = snap_q[{idx_q, 3'b000} +: 8];
      CSUM:    tx.tx_data = csum_q;
      default: tx.tx_data = 8'h00;
    endcase
  end

  assign tx.tx_valid = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == CSUM) & tx.tx_ready;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench: stimulus pushes expected bytes, a monitor pops on each handshake.
module tb_systolic_result_drain;

  logic        clk;
  logic        rst;
  logic [63:0] acc_in;
  logic        acc_valid;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic        clr_ovr;
  logic        ready_mode;
  int          ready_phase;

  systolic_result_drain_if tx_if ();

  systolic_result_drain dut (
    .clk        (clk),
    .rst        (rst),
    .acc_in     (acc_in),
    .acc_valid  (acc_valid),
    .tx         (tx_if),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr)
  );

  // {last, data}
  logic [8:0] exp_q[$];
  int         n_cmp;
  int         n_err;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic [7:0] t2_bytes [10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame from an accumulator vector; only the first n bytes are queued.
  task automatic push_frame(input logic [63:0] acc, input int n);
    logic [7:0] b [10];
    logic [7:0] cs;
    cs = 8'h00;
    b[0] = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      b[i+1] = acc[i*8 +: 8];
      cs = cs ^ acc[i*8 +: 8];
    end
    b[9] = cs;
    for (int i = 0; i < n; i++) exp_q.push_back({(i == 9), b[i]});
  endtask

  task automatic start_frame(input logic [63:0] acc);
    acc_in    = acc;
    acc_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
    acc_in    = 64'hDEAD_BEEF_0BAD_F00D;
  endtask

  task automatic wait_idle(input string name);
    int budget;
    budget = 200;
    while ((exp_q.size() != 0 || busy) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check({name, "_drain_timeout"}, (budget == 0), 0);
  endtask

  // Ready pattern 1,0,0 repeating in mode 1, otherwise tied high.
  initial begin
    tx_if.tx_ready = 1'b1;
    ready_phase    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode) begin
        ready_phase    = (ready_phase == 2) ? 0 : ready_phase + 1;
        tx_if.tx_ready = (ready_phase == 0);
      end else begin
        ready_phase    = 0;
        tx_if.tx_ready = 1'b1;
      end
    end
  end

  initial begin
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (tx_if.tx_valid && tx_if.tx_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {24'h0, tx_if.tx_data}, 32'h1FF);
          end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("tx_data", {24'h0, tx_if.tx_data}, {24'h0, e[7:0]});
            check("frame_done", {31'h0, frame_done}, {31'h0, e[8]});
          end
        end
        if (tx_if.tx_valid && !tx_if.tx_ready) begin
          if (prev_stall) check("stall_hold", {24'h0, tx_if.tx_data}, {24'h0, prev_data});
          prev_stall = 1'b1;
          prev_data  = tx_if.tx_data;
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    acc_in     = 64'h0;
    acc_valid  = 1'b0;
    clr_ovr    = 1'b0;
    ready_mode = 1'b0;
    t2_bytes   = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h04};

    // 1: reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'h0, tx_if.tx_valid}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_overrun", {31'h0, overrun}, 0);
    check("rst_tx_data", {24'h0, tx_if.tx_data}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 2: full-rate frame, exactly 10 cycles, HDR the cycle after the strobe
    for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), t2_bytes[i]});
    start_frame(64'h0004_0003_0002_0001);
    check("latency_valid", {31'h0, tx_if.tx_valid}, 1);
    check("latency_hdr", {24'h0, tx_if.tx_data}, 32'hA5);
    repeat (10) @(posedge clk);
    #1;
    check("t2_len_busy", {31'h0, busy}, 0);
    check("t2_len_q", exp_q.size(), 0);

    // 3: same frame under backpressure
    ready_mode = 1'b1;
    push_frame(64'h0004_0003_0002_0001, 10);
    start_frame(64'h0004_0003_0002_0001);
    wait_idle("t3");
    ready_mode = 1'b0;
    @(posedge clk);
    #1;

    // 4: overrun mid-frame, clear, then set-wins over clear
    push_frame(64'h1111_2222_3333_4444, 10);
    start_frame(64'h1111_2222_3333_4444);
    repeat (2) @(posedge clk);
    #1;
    acc_in    = 64'h9999_8888_7777_6666;
    acc_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
    check("t4_ovr_set", {31'h0, overrun}, 1);
    wait_idle("t4");
    check("t4_ovr_sticky", {31'h0, overrun}, 1);
    clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    clr_ovr = 1'b0;
    check("t4_ovr_clr", {31'h0, overrun}, 0);
    push_frame(64'h0102_0304_0506_0708, 10);
    start_frame(64'h0102_0304_0506_0708);
    acc_valid = 1'b1;
    clr_ovr   = 1'b1;
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
    clr_ovr   = 1'b0;
    check("t4_set_wins", {31'h0, overrun}, 1);
    wait_idle("t4b");
    clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    clr_ovr = 1'b0;
    check("t4b_ovr_clr", {31'h0, overrun}, 0);

    // 5: back-to-back accept on the checksum handshake
    push_frame(64'h00AA_0055_00F0_000F, 10);
    start_frame(64'h00AA_0055_00F0_000F);
    repeat (9) @(posedge clk);
    #1;
    push_frame(64'hFFFF_FFFF_FFFF_FFFF, 10);
    start_frame(64'hFFFF_FFFF_FFFF_FFFF);
    check("t5_no_bubble", {31'h0, tx_if.tx_valid}, 1);
    check("t5_hdr", {24'h0, tx_if.tx_data}, 32'hA5);
    repeat (10) @(posedge clk);
    #1;
    check("t5_busy", {31'h0, busy}, 0);
    check("t5_q", exp_q.size(), 0);
    check("t5_overrun", {31'h0, overrun}, 0);

    // 6: reset during DATA idx 4, then a clean frame
    push_frame(64'h1234_5678_9ABC_DEF0, 5);
    start_frame(64'h1234_5678_9ABC_DEF0);
    repeat (5) @(posedge clk);
    #1;
    check("t6_pre_busy", {31'h0, busy}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_tx_valid", {31'h0, tx_if.tx_valid}, 0);
    check("t6_busy", {31'h0, busy}, 0);
    check("t6_tx_data", {24'h0, tx_if.tx_data}, 0);
    check("t6_partial_q", exp_q.size(), 0);
    push_frame(64'h0F1E_2D3C_4B5A_6978, 10);
    start_frame(64'h0F1E_2D3C_4B5A_6978);
    wait_idle("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
